lb2apb: RTL
===========

Name: lb2apb

Overview:
- Bridge from the local bus (lb_*) to an APB4 initiator: the local-bus responder and APB requester, the reverse of apb2lb.
- Lets register blocks written for the local bus reach peripherals that only expose an APB slave port.
- One transfer in flight; fixed-priority arbitration between local-bus write and read requests.

Parameters:
- ADDR_W, 16, address width for lb_waddr/lb_raddr/paddr
- DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8 is derived internally
- TIMEOUT, 64, max ACCESS cycles before abort (used only with LB2APB_TIMEOUT_EN)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset)
- lb_waddr  input  ADDR_W  write address
- lb_wdata  input  DATA_W  write data
- lb_wstrb  input  STRB_W  write byte strobes
- lb_wen  input  1  write request, held until lb_wready
- lb_wready  output  1  write done, 1-cycle pulse
- lb_raddr  input  ADDR_W  read address
- lb_ren  input  1  read request, held until lb_rvalid
- lb_rdata  output  DATA_W  read data, valid with lb_rvalid
- lb_rvalid  output  1  read done, 1-cycle pulse
- lb_err  output  1  error flag, pulses with lb_wready/lb_rvalid
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_W  APB address
- pwdata  output  DATA_W  APB write data
- pstrb  output  STRB_W  APB byte strobes (0 on reads)
- prdata  input  DATA_W  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB slave error

Behaviour:
- All outputs are registered. Reset (rst=0 at a clk edge) forces them all to 0 and the FSM to IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - lb_wen=1: capture waddr/wdata/wstrb, set pwrite=1, go to SETUP.
  - else lb_ren=1: capture raddr, set pwrite=0, pstrb=0, go to SETUP.
  - Both asserted in the same cycle: write wins; the read stays pending and is taken on the next IDLE.
- SETUP: psel=1, penable=0. Next cycle go to ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwdata/pstrb/pwrite stay stable.
  - pready=0: stay in ACCESS (no wait-state limit without the macro).
  - pready=1: capture prdata (reads only) and pslverr, deassert psel/penable, go to RESP.
- RESP, exactly one cycle:
  - Write: lb_wready=1. Read: lb_rvalid=1 with lb_rdata=captured prdata.
  - lb_err=captured pslverr.
  - Next cycle: IDLE, lb_wready/lb_rvalid/lb_err back to 0, lb_rdata back to 0.
- Latency: request seen in IDLE at cycle N → SETUP at N+1 → ACCESS at N+2 → RESP at N+2+1+k, where k = pready wait states. With zero wait states, the done pulse is at N+3.
- No re-launch during RESP. The request is sampled again only in IDLE, so a master that keeps wen/ren high through the done pulse starts a new transfer.
- Requests arriving outside IDLE are ignored until IDLE. The captured request is unaffected by input changes after capture.
- pslverr on a read: lb_rdata still returns prdata and lb_err=1.
- Reset mid-transfer (any state): next cycle psel=penable=0, no done pulse, pending request discarded.
- paddr/pwdata keep their last values in IDLE. Only psel/penable/done/err/rdata return to 0.

Optional Feature:
- Macro: LB2APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT, the transfer is abandoned: psel/penable drop and the FSM goes to RESP with lb_err=1.
  - Reads in this case return lb_rdata=0.
  - The counter width is $clog2(TIMEOUT+1).
- Not defined: no counter logic is present, and ACCESS waits indefinitely for pready.

Test Plan:
- Write 0x004 ← 0xdeadbeef, strb 0xF, pready held 1 → one SETUP + one ACCESS with paddr=0x004, pwdata=0xdeadbeef, pstrb=0xF, pwrite=1; lb_wready pulse at N+3; lb_err=0.
- Write 0x00c ← 0xcafebabe, strb 0b0110, pready low 5 ACCESS cycles → pstrb=0b0110 stable throughout; lb_wready exactly once, at N+8.
- Read 0x014, slave returns 0xc0debabe after 3 wait states → pwrite=0, pstrb=0; lb_rvalid for 1 cycle with lb_rdata=0xc0debabe; lb_rdata=0 next cycle.
- lb_wen and lb_ren rise together (write 0x010 ← 0x0acce55, read 0x008 → 0xdeadbeef) → APB write completes first, then read; two separate done pulses in that order.
- Read with pslverr=1 at completion → lb_rvalid=1, lb_err=1, lb_rdata=prdata. Second run: rst=0 during ACCESS → psel=0 next cycle, no lb_rvalid.
- LB2APB_TIMEOUT_EN with TIMEOUT=8, pready tied 0 → after 8 ACCESS cycles psel drops; lb_rvalid=1, lb_err=1, lb_rdata=0.

Source files
------------

// File: rtl/lb2apb.sv
// ---------------------------------------------------------------------------
// lb2apb -- local-bus responder to APB4 requester bridge.
//
// Lets register blocks that talk the local bus reach peripherals exposing only
// an APB slave port. One transfer is in flight at a time. When a write and a
// read request are seen together in IDLE, the write is launched first. The
// read stays pending and is taken on the next IDLE cycle.
//
// Optional feature macro: LB2APB_TIMEOUT_EN
//   When defined, an ACCESS phase that sees TIMEOUT cycles with pready=0 is
//   abandoned. The local bus then gets a done pulse with lb_err=1. An
//   abandoned read also returns lb_rdata=0.
//   When undefined, ACCESS waits for pready indefinitely.
//
// Ports:
//   clk                   clock, all logic on the rising edge
//   rst                   synchronous reset, active-low (0 = reset)
//   lb_waddr/wdata/wstrb  local-bus write request fields
//   lb_wen                write request, held until lb_wready
//   lb_wready             write done, 1-cycle pulse
//   lb_raddr              local-bus read address
//   lb_ren                read request, held until lb_rvalid
//   lb_rdata              read data, non-zero only while lb_rvalid
//   lb_rvalid             read done, 1-cycle pulse
//   lb_err                error flag, pulses with lb_wready/lb_rvalid
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB requester outputs
//   prdata/pready/pslverr                    APB completer responses
// ---------------------------------------------------------------------------
module lb2apb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   lb_waddr,
  input  logic [DATA_W-1:0]   lb_wdata,
  input  logic [DATA_W/8-1:0] lb_wstrb,
  input  logic                lb_wen,
  output logic                lb_wready,
  input  logic [ADDR_W-1:0]   lb_raddr,
  input  logic                lb_ren,
  output logic [DATA_W-1:0]   lb_rdata,
  output logic                lb_rvalid,
  output logic                lb_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0] state_reg;

`ifdef LB2APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
`endif

  // pwrite doubles as the "current transfer is a write" flag. It is only
  // reloaded in IDLE, so it stays valid through RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      lb_wready <= 1'b0;
      lb_rvalid <= 1'b0;
      lb_rdata  <= '0;
      lb_err    <= 1'b0;
`ifdef LB2APB_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // Write has fixed priority. A read request held alongside it is
          // taken on a later IDLE cycle.
          if (lb_wen) begin
            paddr     <= lb_waddr;
            pwdata    <= lb_wdata;
            pstrb     <= lb_wstrb;
            pwrite    <= 1'b1;
            psel      <= 1'b1;
            state_reg <= SETUP;
          end else if (lb_ren) begin
            // pwdata is deliberately left at its previous value on reads.
            paddr     <= lb_raddr;
            pstrb     <= {STRB_W{1'b0}};
            pwrite    <= 1'b0;
            psel      <= 1'b1;
            state_reg <= SETUP;
          end
        end

        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
`ifdef LB2APB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end

        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            lb_wready <= pwrite;
            lb_rvalid <= ~pwrite;
            lb_rdata  <= pwrite ? {DATA_W{1'b0}} : prdata;
            lb_err    <= pslverr;
            state_reg <= RESP;
          end
`ifdef LB2APB_TIMEOUT_EN
          // This cycle is the TIMEOUT-th wait state. Abandon the transfer
          // and report an error with zero read data.
          else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            lb_wready <= pwrite;
            lb_rvalid <= ~pwrite;
            lb_rdata  <= {DATA_W{1'b0}};
            lb_err    <= 1'b1;
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        RESP: begin
          // The done pulse lasts one cycle. Requests are not sampled here,
          // so a master still holding wen/ren is served from IDLE.
          lb_wready <= 1'b0;
          lb_rvalid <= 1'b0;
          lb_rdata  <= '0;
          lb_err    <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
